// File: rtl/ex_pkg.sv
// Shared types and helpers for the RV32 execute stage: ALU opcodes, forward codes,
// multiplier FSM states, and the combinational ALU and forwarding functions.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_MUL   = 4'd11
  } alu_op_e;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EX_MEM  = 2'b01;
  localparam logic [1:0] FWD_MEM_WB  = 2'b10;
  localparam logic [1:0] FWD_WB      = 2'b11;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_e;

  function automatic logic [31:0] fwd_mux(input logic [1:0] code,
                                          input logic [31:0] rf,
                                          input logic [31:0] ex_mem,
                                          input logic [31:0] mem_wb,
                                          input logic [31:0] wb);
    case (code)
      FWD_EX_MEM: fwd_mux = ex_mem;
      FWD_MEM_WB: fwd_mux = mem_wb;
      FWD_WB:     fwd_mux = wb;
      default:    fwd_mux = rf;
    endcase
  endfunction

  // MUL is not handled here; it comes from the iterative core when enabled.
  function automatic logic [31:0] alu_compute(input alu_op_e op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
    case (op)
      ALU_ADD:   alu_compute = a + b;
      ALU_SUB:   alu_compute = a - b;
      ALU_AND:   alu_compute = a & b;
      ALU_OR:    alu_compute = a | b;
      ALU_XOR:   alu_compute = a ^ b;
      ALU_SLL:   alu_compute = a << b[4:0];
      ALU_SRL:   alu_compute = a >> b[4:0];
      ALU_SRA:   alu_compute = $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:   alu_compute = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  alu_compute = {31'd0, a < b};
      ALU_PASSB: alu_compute = b;
      default:   alu_compute = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_iter_mul.sv
// Radix-2 shift-add multiplier: 32 RUN cycles, low 32 bits of a*b presented
// combinationally with done in the final (count 31) cycle.
module iter_mul
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  mul_state_e  state;
  logic [4:0]  count;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [31:0] partial;

  assign partial = mplier[0] ? mcand : 32'd0;
  assign result  = acc + partial;
  assign done    = (state == MUL_RUN) && !abort && (count == 5'd31);
  // Busy covers the launch cycle and every RUN cycle except the final one.
  assign busy    = ((state == MUL_IDLE) && start) ||
                   ((state == MUL_RUN) && !abort && (count != 5'd31));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= MUL_IDLE;
      count  <= 5'd0;
      acc    <= 32'd0;
      mcand  <= 32'd0;
      mplier <= 32'd0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (start) begin
            state  <= MUL_RUN;
            count  <= 5'd0;
            acc    <= 32'd0;
            mcand  <= a;
            mplier <= b;
          end
        end
        default: begin
          if (abort || (count == 5'd31)) begin
            state <= MUL_IDLE;
            count <= 5'd0;
          end else begin
            count  <= count + 5'd1;
            acc    <= acc + partial;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/ex_stage.sv
// RV32 execute stage: forwarding muxes, ALU and EX/MEM register.
// Define EX_MUL_EN to add the 33-cycle iterative MUL with the ex_busy stall.
module ex_stage
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        id_ex_valid,
  input  logic [3:0]  id_ex_alu_op,
  input  logic        id_ex_alu_src,
  input  logic [31:0] id_ex_rs1_data,
  input  logic [31:0] id_ex_rs2_data,
  input  logic [31:0] id_ex_imm,
  input  logic        id_ex_reg_write_enable,
  input  logic        id_ex_reg_write_select,
  input  logic [4:0]  id_ex_reg_write_addr,
  input  logic        id_ex_mem_write,
  input  logic [1:0]  forward_1,
  input  logic [1:0]  forward_2,
  input  logic [31:0] mem_wb_write_data,
  input  logic [31:0] wb_write_data,
  output logic        ex_mem_valid,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_store_data,
  output logic        ex_mem_reg_write_enable,
  output logic        ex_mem_reg_write_select,
  output logic        ex_mem_mem_write,
  output logic [4:0]  ex_mem_reg_write_addr,
  output logic        ex_busy
);

  logic [31:0] op_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] alu_y;
  logic [31:0] ex_result;

  assign op_a  = fwd_mux(forward_1, id_ex_rs1_data, ex_mem_alu_result,
                         mem_wb_write_data, wb_write_data);
  assign fwd_b = fwd_mux(forward_2, id_ex_rs2_data, ex_mem_alu_result,
                         mem_wb_write_data, wb_write_data);
  assign op_b  = id_ex_alu_src ? id_ex_imm : fwd_b;
  assign alu_y = alu_compute(alu_op_e'(id_ex_alu_op), op_a, op_b);

`ifdef EX_MUL_EN
  logic        mul_start;
  logic        mul_done;
  logic [31:0] mul_y;

  assign mul_start = id_ex_valid && (id_ex_alu_op == ALU_MUL) && !flush;

  iter_mul u_iter_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .abort  (flush),
    .a      (op_a),
    .b      (op_b),
    .busy   (ex_busy),
    .done   (mul_done),
    .result (mul_y)
  );

  assign ex_result = mul_done ? mul_y : alu_y;
`else
  assign ex_busy   = 1'b0;
  assign ex_result = alu_y;
`endif

  // rst > flush > busy > normal; every non-normal case loads an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst || flush || ex_busy || !id_ex_valid) begin
      ex_mem_valid            <= 1'b0;
      ex_mem_alu_result       <= 32'd0;
      ex_mem_store_data       <= 32'd0;
      ex_mem_reg_write_enable <= 1'b0;
      ex_mem_reg_write_select <= 1'b0;
      ex_mem_mem_write        <= 1'b0;
      ex_mem_reg_write_addr   <= 5'd0;
    end else begin
      ex_mem_valid            <= 1'b1;
      ex_mem_alu_result       <= ex_result;
      ex_mem_store_data       <= fwd_b;
      ex_mem_reg_write_enable <= id_ex_reg_write_enable;
      ex_mem_reg_write_select <= id_ex_reg_write_select;
      ex_mem_mem_write        <= id_ex_mem_write;
      ex_mem_reg_write_addr   <= id_ex_reg_write_addr;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for the single-cycle ALU/forwarding
// path plus hand-written MUL, flush and reset sequences when EX_MUL_EN is defined.
module tb_ex_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        id_ex_valid;
  logic [3:0]  id_ex_alu_op;
  logic        id_ex_alu_src;
  logic [31:0] id_ex_rs1_data;
  logic [31:0] id_ex_rs2_data;
  logic [31:0] id_ex_imm;
  logic        id_ex_reg_write_enable;
  logic        id_ex_reg_write_select;
  logic [4:0]  id_ex_reg_write_addr;
  logic        id_ex_mem_write;
  logic [1:0]  forward_1;
  logic [1:0]  forward_2;
  logic [31:0] mem_wb_write_data;
  logic [31:0] wb_write_data;
  logic        ex_mem_valid;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_store_data;
  logic        ex_mem_reg_write_enable;
  logic        ex_mem_reg_write_select;
  logic        ex_mem_mem_write;
  logic [4:0]  ex_mem_reg_write_addr;
  logic        ex_busy;

  int n_checks;
  int n_fails;

  ex_stage dut (
    .clk                     (clk),
    .rst                     (rst),
    .flush                   (flush),
    .id_ex_valid             (id_ex_valid),
    .id_ex_alu_op            (id_ex_alu_op),
    .id_ex_alu_src           (id_ex_alu_src),
    .id_ex_rs1_data          (id_ex_rs1_data),
    .id_ex_rs2_data          (id_ex_rs2_data),
    .id_ex_imm               (id_ex_imm),
    .id_ex_reg_write_enable  (id_ex_reg_write_enable),
    .id_ex_reg_write_select  (id_ex_reg_write_select),
    .id_ex_reg_write_addr    (id_ex_reg_write_addr),
    .id_ex_mem_write         (id_ex_mem_write),
    .forward_1               (forward_1),
    .forward_2               (forward_2),
    .mem_wb_write_data       (mem_wb_write_data),
    .wb_write_data           (wb_write_data),
    .ex_mem_valid            (ex_mem_valid),
    .ex_mem_alu_result       (ex_mem_alu_result),
    .ex_mem_store_data       (ex_mem_store_data),
    .ex_mem_reg_write_enable (ex_mem_reg_write_enable),
    .ex_mem_reg_write_select (ex_mem_reg_write_select),
    .ex_mem_mem_write        (ex_mem_mem_write),
    .ex_mem_reg_write_addr   (ex_mem_reg_write_addr),
    .ex_busy                 (ex_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        flush;
    logic [3:0]  op;
    logic        src;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [1:0]  f1;
    logic [1:0]  f2;
    logic        mw;
    logic        rwe;
    logic [31:0] exp_res;
    logic [31:0] exp_store;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic valid, input logic fl, input logic [3:0] op,
                              input logic src, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] imm,
                              input logic [1:0] f1, input logic [1:0] f2,
                              input logic mw, input logic rwe,
                              input logic [31:0] exp_res, input logic [31:0] exp_store);
    vec_t v;
    v.valid = valid; v.flush = fl; v.op = op; v.src = src;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.f1 = f1; v.f2 = f2;
    v.mw = mw; v.rwe = rwe; v.exp_res = exp_res; v.exp_store = exp_store;
    return v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [3:0] op, input logic src,
                       input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic rwe, input logic [4:0] rd);
    id_ex_valid            = valid;
    id_ex_alu_op           = op;
    id_ex_alu_src          = src;
    id_ex_rs1_data         = rs1;
    id_ex_rs2_data         = rs2;
    id_ex_imm              = imm;
    id_ex_reg_write_enable = rwe;
    id_ex_reg_write_select = 1'b1;
    id_ex_reg_write_addr   = rd;
    id_ex_mem_write        = 1'b0;
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_bubble(input string name);
    check({name, ".valid"}, {31'd0, ex_mem_valid}, 32'd0);
    check({name, ".rwe"},   {31'd0, ex_mem_reg_write_enable}, 32'd0);
    check({name, ".mw"},    {31'd0, ex_mem_mem_write}, 32'd0);
    check({name, ".res"},   ex_mem_alu_result, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    flush = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    forward_1 = 2'b00;
    forward_2 = 2'b00;
    mem_wb_write_data = 32'h22;
    wb_write_data     = 32'h33;

    tick();
    tick();
    check_bubble("reset");
    check("reset.store", ex_mem_store_data, 32'd0);
    check("reset.rws",   {31'd0, ex_mem_reg_write_select}, 32'd0);
    check("reset.rd",    {27'd0, ex_mem_reg_write_addr}, 32'd0);
    check("reset.busy",  {31'd0, ex_busy}, 32'd0);
    rst = 1'b0;

    vecs[0]  = mk(1, 0, 4'd0,  1, 32'd5,        32'd0,        32'd7,        2'b00, 2'b00, 0, 1, 32'd12,       32'd0);
    vecs[1]  = mk(1, 0, 4'd1,  0, 32'd3,        32'd5,        32'd0,        2'b00, 2'b00, 0, 1, 32'hFFFFFFFE, 32'd5);
    vecs[2]  = mk(1, 0, 4'd7,  1, 32'h80000000, 32'd0,        32'd4,        2'b00, 2'b00, 0, 1, 32'hF8000000, 32'd0);
    vecs[3]  = mk(1, 0, 4'd9,  0, 32'd1,        32'hFFFFFFFF, 32'd0,        2'b00, 2'b00, 0, 1, 32'd1,        32'hFFFFFFFF);
    vecs[4]  = mk(1, 0, 4'd8,  0, 32'hFFFFFFFF, 32'd1,        32'd0,        2'b00, 2'b00, 0, 1, 32'd1,        32'd1);
    vecs[5]  = mk(1, 0, 4'd2,  1, 32'hF0F0F0F0, 32'd0,        32'h0FF00FF0, 2'b00, 2'b00, 0, 1, 32'h00F000F0, 32'd0);
    vecs[6]  = mk(1, 0, 4'd3,  1, 32'h00000F00, 32'd0,        32'h000000F0, 2'b00, 2'b00, 0, 1, 32'h00000FF0, 32'd0);
    vecs[7]  = mk(1, 0, 4'd4,  1, 32'hFFFF0000, 32'd0,        32'hFF00FF00, 2'b00, 2'b00, 0, 1, 32'h00FFFF00, 32'd0);
    vecs[8]  = mk(1, 0, 4'd5,  1, 32'd1,        32'd0,        32'h21,       2'b00, 2'b00, 0, 1, 32'd2,        32'd0);
    vecs[9]  = mk(1, 0, 4'd6,  1, 32'h80000000, 32'd0,        32'd31,       2'b00, 2'b00, 0, 1, 32'd1,        32'd0);
    vecs[10] = mk(1, 0, 4'd10, 1, 32'hDEADBEEF, 32'd0,        32'h12345000, 2'b00, 2'b00, 0, 1, 32'h12345000, 32'd0);
    vecs[11] = mk(1, 0, 4'd12, 1, 32'd5,        32'd0,        32'd7,        2'b00, 2'b00, 0, 1, 32'd0,        32'd0);
    vecs[12] = mk(1, 0, 4'd0,  1, 32'h11,       32'd0,        32'd0,        2'b00, 2'b00, 0, 1, 32'h11,       32'd0);
    vecs[13] = mk(1, 0, 4'd0,  1, 32'h99,       32'd0,        32'd0,        2'b01, 2'b00, 0, 1, 32'h11,       32'd0);
    vecs[14] = mk(1, 0, 4'd0,  1, 32'h99,       32'd0,        32'd0,        2'b10, 2'b00, 0, 1, 32'h22,       32'd0);
    vecs[15] = mk(1, 0, 4'd0,  1, 32'h99,       32'd0,        32'd0,        2'b11, 2'b00, 0, 1, 32'h33,       32'd0);
    vecs[16] = mk(1, 0, 4'd0,  1, 32'h100,      32'h77,       32'd8,        2'b00, 2'b10, 1, 0, 32'h108,      32'h22);
    vecs[17] = mk(0, 0, 4'd0,  1, 32'd5,        32'd6,        32'd7,        2'b00, 2'b00, 1, 1, 32'd0,        32'd0);
    vecs[18] = mk(1, 1, 4'd0,  1, 32'd5,        32'd6,        32'd7,        2'b00, 2'b00, 1, 1, 32'd0,        32'd0);

    for (int i = 0; i < NV; i++) begin
      logic exp_valid;
      string nm;
      nm = $sformatf("vec%0d", i);
      exp_valid = vecs[i].valid && !vecs[i].flush;
      flush                  = vecs[i].flush;
      id_ex_valid            = vecs[i].valid;
      id_ex_alu_op           = vecs[i].op;
      id_ex_alu_src          = vecs[i].src;
      id_ex_rs1_data         = vecs[i].rs1;
      id_ex_rs2_data         = vecs[i].rs2;
      id_ex_imm              = vecs[i].imm;
      id_ex_reg_write_enable = vecs[i].rwe;
      id_ex_reg_write_select = i[0];
      id_ex_reg_write_addr   = 5'(i + 1);
      id_ex_mem_write        = vecs[i].mw;
      forward_1              = vecs[i].f1;
      forward_2              = vecs[i].f2;
      tick();
      check({nm, ".res"},   ex_mem_alu_result, vecs[i].exp_res);
      check({nm, ".store"}, ex_mem_store_data, vecs[i].exp_store);
      check({nm, ".valid"}, {31'd0, ex_mem_valid}, {31'd0, exp_valid});
      check({nm, ".rwe"},   {31'd0, ex_mem_reg_write_enable}, {31'd0, exp_valid && vecs[i].rwe});
      check({nm, ".mw"},    {31'd0, ex_mem_mem_write}, {31'd0, exp_valid && vecs[i].mw});
      check({nm, ".rws"},   {31'd0, ex_mem_reg_write_select}, {31'd0, exp_valid && i[0]});
      check({nm, ".rd"},    {27'd0, ex_mem_reg_write_addr}, exp_valid ? 32'(i + 1) : 32'd0);
    end
    flush = 1'b0;
    forward_1 = 2'b00;
    forward_2 = 2'b00;

`ifdef EX_MUL_EN
    // MUL 0xFFFFFFFF x 3 with forward sources disturbed mid-run
    drive(1'b1, 4'd11, 1'b0, 32'hFFFFFFFF, 32'd3, 32'd0, 1'b1, 5'd7);
    #1;
    check("mul.busy_c0", {31'd0, ex_busy}, 32'd1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 5) begin
        forward_1 = 2'b10;
        forward_2 = 2'b11;
        mem_wb_write_data = 32'hDEAD;
        wb_write_data     = 32'hBEEF;
      end
      check($sformatf("mul.busy_c%0d", k), {31'd0, ex_busy}, (k < 32) ? 32'd1 : 32'd0);
      if (k < 32) check($sformatf("mul.bubble_c%0d", k), {31'd0, ex_mem_valid}, 32'd0);
    end
    tick();
    check("mul.result", ex_mem_alu_result, 32'hFFFFFFFD);
    check("mul.valid",  {31'd0, ex_mem_valid}, 32'd1);
    check("mul.rd",     {27'd0, ex_mem_reg_write_addr}, 32'd7);
    drive(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    forward_1 = 2'b00;
    forward_2 = 2'b00;
    mem_wb_write_data = 32'h22;
    wb_write_data     = 32'h33;
    tick();
    check("mul.after_busy", {31'd0, ex_busy}, 32'd0);

    // flush at RUN count 10 (cycle 11)
    drive(1'b1, 4'd11, 1'b0, 32'd7, 32'd9, 32'd0, 1'b1, 5'd3);
    for (int k = 1; k <= 11; k++) tick();
    check("flush.busy_before", {31'd0, ex_busy}, 32'd1);
    flush = 1'b1;
    #1;
    check("flush.busy_same_cycle", {31'd0, ex_busy}, 32'd0);
    tick();
    check_bubble("flush");
    flush = 1'b0;
    drive(1'b1, 4'd0, 1'b1, 32'd2, 32'd0, 32'd3, 1'b1, 5'd4);
    #1;
    check("flush.add_busy", {31'd0, ex_busy}, 32'd0);
    tick();
    check("flush.add_res",   ex_mem_alu_result, 32'd5);
    check("flush.add_valid", {31'd0, ex_mem_valid}, 32'd1);

    // reset in the middle of a MUL
    drive(1'b1, 4'd11, 1'b0, 32'd7, 32'd9, 32'd0, 1'b1, 5'd3);
    for (int k = 1; k <= 5; k++) tick();
    rst = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    tick();
    check_bubble("rst_mid_mul");
    check("rst_mid_mul.busy", {31'd0, ex_busy}, 32'd0);
    rst = 1'b0;
    drive(1'b1, 4'd0, 1'b1, 32'd10, 32'd0, 32'd1, 1'b1, 5'd2);
    tick();
    check("rst_mid_mul.add_res", ex_mem_alu_result, 32'd11);
`else
    // without the multiplier MUL behaves like an undefined opcode
    drive(1'b1, 4'd11, 1'b0, 32'd3, 32'd4, 32'd0, 1'b1, 5'd9);
    #1;
    check("mul_off.busy", {31'd0, ex_busy}, 32'd0);
    tick();
    check("mul_off.res",   ex_mem_alu_result, 32'd0);
    check("mul_off.valid", {31'd0, ex_mem_valid}, 32'd1);
    check("mul_off.rd",    {27'd0, ex_mem_reg_write_addr}, 32'd9);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
